// File: rtl/serial_word_capture.sv
// Samples I_SDATA on rising edges of the divided serial clock, assembles MSB-first
// words and buffers them in a first-word-fall-through FIFO with word count and overflow.
module serial_word_capture #(
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int LEVEL_WIDTH = 4
) (
    input  logic                   I_CLK,
    input  logic                   I_RST,
    input  logic                   I_START,
    input  logic                   I_SCLK,
    input  logic                   I_SDATA,
    output logic [DATA_WIDTH-1:0]  O_DATA,
    output logic                   O_VALID,
    input  logic                   I_READY,
    output logic [LEVEL_WIDTH-1:0] O_FIFO_LEVEL,
    output logic [31:0]            O_WORD_COUNT,
    output logic                   O_OVERFLOW
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, CAPTURE} state_t;
    state_t state, state_nxt;

    logic                  sclk_d, rise;
    logic [DATA_WIDTH-1:0] shift, shift_nxt, r_word;
    logic [CW-1:0]         bit_cnt;
    logic                  r_push;
    logic                  cap_en, restart, hold_clr;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr, ptr_diff;
    logic                  empty, full, pop, push_ok, drop;

    // ---------------- FSM ----------------
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (I_START)  state_nxt = CAPTURE;
            CAPTURE: if (!I_START) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cap_en   = (state == CAPTURE);
        restart  = (state == IDLE) && I_START;
        hold_clr = !I_START;
    end

    // ---------------- bit capture ----------------
    assign rise      = I_SCLK & ~sclk_d & I_START;
    assign shift_nxt = {shift[DATA_WIDTH-2:0], I_SDATA};

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            sclk_d  <= 1'b0;
            shift   <= '0;
            bit_cnt <= '0;
            r_push  <= 1'b0;
            r_word  <= '0;
        end else begin
            sclk_d <= I_SCLK;
            r_push <= 1'b0;
            if (hold_clr) begin
                shift   <= '0;
                bit_cnt <= '0;
            end else if (cap_en && rise) begin
                shift <= shift_nxt;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt <= '0;
                    r_push  <= 1'b1;
                    r_word  <= shift_nxt;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    // ---------------- FIFO ----------------
    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = !empty && I_READY;
    assign push_ok  = r_push && (!full || pop);
    assign drop     = r_push && full && !pop;
    assign ptr_diff = wr_ptr - rd_ptr;

    always_ff @(posedge I_CLK) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= r_word;
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            O_WORD_COUNT <= '0;
            O_OVERFLOW   <= 1'b0;
        end else if (restart) begin
            O_WORD_COUNT <= '0;
            O_OVERFLOW   <= 1'b0;
        end else begin
            if (push_ok && O_WORD_COUNT != 32'hFFFF_FFFF)
                O_WORD_COUNT <= O_WORD_COUNT + 32'd1;
            if (drop)
                O_OVERFLOW <= 1'b1;
        end
    end

    // Head word is gated so every output reads 0 straight out of reset.
    assign O_VALID      = !empty;
    assign O_DATA       = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign O_FIFO_LEVEL = LEVEL_WIDTH'(ptr_diff);

endmodule

// File: tb/tb_serial_word_capture.sv
// Randomized and directed bench for serial_word_capture against a queue-based
// cycle model; also pins the model with hand-computed expectations.
module tb_serial_word_capture;
    localparam int DW = 16;
    localparam int DEPTH = 8;
    localparam int LW = 4;

    logic          I_CLK = 0, I_RST = 1, I_START = 0, I_SCLK = 0, I_SDATA = 0, I_READY = 0;
    logic [DW-1:0] O_DATA;
    logic          O_VALID, O_OVERFLOW;
    logic [LW-1:0] O_FIFO_LEVEL;
    logic [31:0]   O_WORD_COUNT;

    serial_word_capture #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .LEVEL_WIDTH(LW)) dut (
        .I_CLK(I_CLK), .I_RST(I_RST), .I_START(I_START), .I_SCLK(I_SCLK),
        .I_SDATA(I_SDATA), .O_DATA(O_DATA), .O_VALID(O_VALID), .I_READY(I_READY),
        .O_FIFO_LEVEL(O_FIFO_LEVEL), .O_WORD_COUNT(O_WORD_COUNT), .O_OVERFLOW(O_OVERFLOW)
    );

    always #5 I_CLK = ~I_CLK;

    // ---------------- reference model ----------------
    logic [DW-1:0] m_fifo[$];
    logic [DW-1:0] m_word = 0, m_pend = 0;
    int            m_nbits = 0;
    bit            m_pend_v = 0, m_cap = 0, m_prev = 0, m_ovf = 0;
    logic [31:0]   m_cnt = 0;

    always @(posedge I_CLK or posedge I_RST) begin : model
        bit do_pop, acc;
        if (I_RST) begin
            m_fifo.delete();
            m_word = 0; m_pend = 0; m_nbits = 0; m_pend_v = 0;
            m_cap = 0; m_prev = 0; m_ovf = 0; m_cnt = 0;
        end else begin
            do_pop = (m_fifo.size() != 0) && I_READY;
            acc    = (m_fifo.size() < DEPTH) || do_pop;
            if (do_pop) void'(m_fifo.pop_front());
            if (m_pend_v) begin
                if (acc) begin
                    m_fifo.push_back(m_pend);
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                end else m_ovf = 1;
            end
            if (!m_cap && I_START) begin m_cnt = 0; m_ovf = 0; end
            m_pend_v = 0;
            if (m_cap && I_START && I_SCLK && !m_prev) begin
                m_word  = {m_word[DW-2:0], I_SDATA};
                m_nbits = m_nbits + 1;
                if (m_nbits == DW) begin
                    m_pend = m_word; m_pend_v = 1; m_nbits = 0; m_word = 0;
                end
            end
            if (!I_START) begin m_nbits = 0; m_word = 0; end
            m_cap  = I_START;
            m_prev = I_SCLK;
        end
    end

    // ---------------- checking ----------------
    int vectors = 0, miscompares = 0;
    bit rnd_ready = 0;
    logic [DW-1:0] popped[$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle: log the pop about to happen, then compare against the model.
    task automatic tick();
        if (rnd_ready) I_READY = 1'($urandom_range(0, 1));
        if (O_VALID && I_READY) popped.push_back(O_DATA);
        @(negedge I_CLK);
        cmp("valid", 32'(O_VALID), 32'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) cmp("data", 32'(O_DATA), 32'(m_fifo[0]));
        cmp("level", 32'(O_FIFO_LEVEL), 32'(m_fifo.size()));
        cmp("count", O_WORD_COUNT, m_cnt);
        cmp("overflow", 32'(O_OVERFLOW), 32'(m_ovf));
    endtask

    task automatic send_bit(input logic b, input int half);
        I_SDATA = b; I_SCLK = 0;
        repeat (half) tick();
        I_SCLK = 1;
        repeat (half) tick();
    endtask

    // pulse_ready raises I_READY for exactly the cycle the word enters the FIFO.
    task automatic send_word(input logic [DW-1:0] w, input int half, input bit pulse_ready);
        for (int i = DW - 1; i >= 0; i--) begin
            if (i == 0 && pulse_ready) begin
                I_SDATA = w[0]; I_SCLK = 0;
                repeat (half) tick();
                I_SCLK = 1;
                tick();
                I_READY = 1;
                tick();
                I_READY = 0;
                repeat (half) tick();
            end else send_bit(w[i], half);
        end
    endtask

    task automatic restart();
        I_START = 0; tick(); tick();
        I_START = 1; tick(); tick();
    endtask

    task automatic check_popped(input string name, input logic [DW-1:0] exp[$]);
        cmp({name, "_n"}, popped.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) cmp(name, 32'(popped[i]), 32'(exp[i]));
        popped.delete();
    endtask

    initial begin
        logic [DW-1:0] exp[$];
        repeat (2) tick();
        cmp("rst_valid", 32'(O_VALID), 0);
        cmp("rst_data", 32'(O_DATA), 0);
        cmp("rst_level", 32'(O_FIFO_LEVEL), 0);
        cmp("rst_count", O_WORD_COUNT, 0);
        cmp("rst_ovf", 32'(O_OVERFLOW), 0);
        I_RST = 0; tick();

        // single word, divider 10
        I_START = 1; tick(); tick();
        I_READY = 1;
        send_word(16'hA5C3, 5, 0);
        repeat (4) tick();
        exp = '{16'hA5C3}; check_popped("t1_word", exp);
        cmp("t1_count", O_WORD_COUNT, 1);
        cmp("t1_level", 32'(O_FIFO_LEVEL), 0);

        // overflow with nine words into eight entries
        I_READY = 0; restart();
        for (int k = 1; k <= 9; k++) send_word(DW'(k), 2, 0);
        repeat (4) tick();
        cmp("t2_level", 32'(O_FIFO_LEVEL), 8);
        cmp("t2_ovf", 32'(O_OVERFLOW), 1);
        cmp("t2_count", O_WORD_COUNT, 8);
        I_READY = 1; repeat (12) tick(); I_READY = 0;
        exp = '{1, 2, 3, 4, 5, 6, 7, 8}; check_popped("t2_drain", exp);

        // push coinciding with a pop while full
        restart();
        for (int k = 0; k < 8; k++) send_word(DW'(16'h10 + k), 2, 0);
        send_word(16'h18, 2, 1);
        repeat (3) tick();
        cmp("t3_level", 32'(O_FIFO_LEVEL), 8);
        cmp("t3_ovf", 32'(O_OVERFLOW), 0);
        cmp("t3_count", O_WORD_COUNT, 9);
        I_READY = 1; repeat (12) tick(); I_READY = 0;
        exp = '{16'h10, 16'h11, 16'h12, 16'h13, 16'h14, 16'h15, 16'h16, 16'h17, 16'h18};
        check_popped("t3_drain", exp);

        // partial word discarded on start drop; buffered data still readable
        send_word(16'hBEEF, 2, 0);
        for (int k = 0; k < 5; k++) send_bit(1'b1, 2);
        I_START = 0; repeat (3) tick();
        cmp("t4_count_held", O_WORD_COUNT, 10);
        cmp("t4_level", 32'(O_FIFO_LEVEL), 1);
        I_READY = 1; repeat (3) tick();
        exp = '{16'hBEEF}; check_popped("t4_buffered", exp);
        I_START = 1; tick(); tick();
        send_word(16'h1234, 2, 0);
        repeat (4) tick();
        exp = '{16'h1234}; check_popped("t4_word", exp);
        cmp("t4_count", O_WORD_COUNT, 1);
        cmp("t4_ovf", 32'(O_OVERFLOW), 0);

        // async reset mid-word with three words buffered
        I_READY = 0;
        send_word(16'h0011, 2, 0); send_word(16'h0022, 2, 0); send_word(16'h0033, 2, 0);
        for (int k = 0; k < 10; k++) send_bit(k[0], 2);
        #2 I_RST = 1;
        #1;
        cmp("t5_valid", 32'(O_VALID), 0);
        cmp("t5_data", 32'(O_DATA), 0);
        cmp("t5_level", 32'(O_FIFO_LEVEL), 0);
        cmp("t5_count", O_WORD_COUNT, 0);
        tick(); tick();
        I_RST = 0; tick(); tick();
        I_READY = 1;
        send_word(16'hFFFF, 2, 0);
        repeat (4) tick();
        exp = '{16'hFFFF}; check_popped("t5_word", exp);
        cmp("t5_count_after", O_WORD_COUNT, 1);

        // back-to-back at divider 2
        send_word(16'h8000, 1, 0);
        send_word(16'h0001, 1, 0);
        repeat (4) tick();
        exp = '{16'h8000, 16'h0001}; check_popped("t6_b2b", exp);

        // randomized traffic against the model
        rnd_ready = 1;
        for (int n = 0; n < 120; n++) begin
            int half;
            half = $urandom_range(1, 3);
            if ($urandom_range(0, 9) == 0) begin
                int nb;
                nb = $urandom_range(1, DW - 1);
                for (int k = 0; k < nb; k++) send_bit(1'($urandom_range(0, 1)), half);
                I_START = 0;
                repeat ($urandom_range(1, 3)) tick();
                I_START = 1; tick();
            end
            send_word(DW'($urandom), half, 0);
        end
        rnd_ready = 0; I_READY = 1;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
